// File: rtl/cdc_fifo_pkg.sv
// rtl/cdc_fifo_pkg.sv - shared types and constants for the CDC FIFO read arbiter
package cdc_fifo_pkg;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} arb_state_t;

  localparam int STATS_W = 16;

endpackage

// File: rtl/cdc_fifo_read_arbiter_if.sv
// rtl/cdc_fifo_read_arbiter_if.sv - FIFO read port and per-requester output handshake bundle
interface cdc_fifo_read_arbiter_if #(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 8
);

  logic                      fifo_empty;
  logic [DATA_WIDTH-1:0]     fifo_read_data;
  logic                      fifo_increment;
  logic [NUM_REQUESTERS-1:0] req;
  logic [NUM_REQUESTERS-1:0] out_ready;
  logic [NUM_REQUESTERS-1:0] out_valid;
  logic [DATA_WIDTH-1:0]     out_data;
  logic [NUM_REQUESTERS-1:0] grant;
  logic                      busy;

  modport master (
    input  fifo_empty, fifo_read_data, req, out_ready,
    output fifo_increment, out_valid, out_data, grant, busy
  );

  modport slave (
    output fifo_empty, fifo_read_data, req, out_ready,
    input  fifo_increment, out_valid, out_data, grant, busy
  );

endinterface

// File: rtl/cdc_fifo_read_arbiter_rr_priority_pick.sv
// rtl/cdc_fifo_read_arbiter_rr_priority_pick.sv - one-hot pick of the first request at or after rr_ptr
module rr_priority_pick #(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic [NUM_REQUESTERS-1:0]         req,
  input  logic [$clog2(NUM_REQUESTERS)-1:0] rr_ptr,
  output logic [NUM_REQUESTERS-1:0]         pick
);

  localparam int PTR_W = $clog2(NUM_REQUESTERS);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < NUM_REQUESTERS; off++) begin
      idx = PTR_W'((int'(rr_ptr) + off) % NUM_REQUESTERS);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdc_fifo_read_arbiter.sv
// rtl/cdc_fifo_read_arbiter.sv - round-robin burst arbiter on the CDC FIFO read port
// Optional statistics counters enabled by CDC_FIFO_ARB_STATS_EN.
import cdc_fifo_pkg::*;

module cdc_fifo_read_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_BURST      = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  cdc_fifo_read_arbiter_if.master bus
`ifdef CDC_FIFO_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]   words_delivered,
  output logic [STATS_W-1:0]   grants_issued
`endif
);

  localparam int PTR_W = $clog2(NUM_REQUESTERS);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_REQUESTERS - 1);

  arb_state_t                state_q, state_d;
  logic [NUM_REQUESTERS-1:0] grant_q, grant_d;
  logic [NUM_REQUESTERS-1:0] valid_q, valid_d;
  logic [NUM_REQUESTERS-1:0] pick;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]          owner;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      owner_req, owner_ready, owner_valid;
  logic                      accept, load, start;

  rr_priority_pick #(
    .NUM_REQUESTERS(NUM_REQUESTERS)
  ) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .pick   (pick)
  );

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant_q[i]) owner = PTR_W'(i);
    end
  end

  // valid_q only ever carries the owner's bit, so indexing by owner is enough
  assign owner_req   = bus.req[owner];
  assign owner_ready = bus.out_ready[owner];
  assign owner_valid = valid_q[owner];
  assign accept      = owner_valid & owner_ready;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    valid_d  = valid_q;
    data_d   = data_q;
    load     = 1'b0;
    start    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_d = pick;
          count_d = '0;
          state_d = BURST;
          start   = 1'b1;
        end
      end
      BURST: begin
        load = !bus.fifo_empty && owner_req && (count_q < BURST_LAST) &&
               (!owner_valid || owner_ready);
        if (load) begin
          data_d  = bus.fifo_read_data;
          valid_d = grant_q;
          count_d = count_q + 1'b1;
        end else if (accept) begin
          valid_d = '0;
        end
        // exit decision sees the count after this cycle's load
        if ((count_d == BURST_LAST) || !owner_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (accept) valid_d = '0;
        if (!owner_valid || accept) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = (owner == PTR_LAST) ? '0 : owner + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      valid_q  <= '0;
      data_q   <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.fifo_increment = load;
  assign bus.out_valid      = valid_q;
  assign bus.out_data       = data_q;
  assign bus.grant          = grant_q;
  assign bus.busy           = (state_q != IDLE);

`ifdef CDC_FIFO_ARB_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      words_delivered <= '0;
      grants_issued   <= '0;
    end else begin
      if (accept) words_delivered <= words_delivered + 1'b1;
      if (start)  grants_issued   <= grants_issued + 1'b1;
    end
  end
`else
  logic unused_start;
  assign unused_start = start;
`endif

endmodule

// File: tb/tb_cdc_fifo_read_arbiter.sv
// tb/tb_cdc_fifo_read_arbiter.sv - scoreboard bench for cdc_fifo_read_arbiter
module tb_cdc_fifo_read_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  cdc_fifo_read_arbiter_if #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW)) bus ();

`ifdef CDC_FIFO_ARB_STATS_EN
  logic [15:0] words_delivered;
  logic [15:0] grants_issued;
`endif

  cdc_fifo_read_arbiter #(
    .NUM_REQUESTERS(N),
    .DATA_WIDTH(DW),
    .MAX_BURST(MB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef CDC_FIFO_ARB_STATS_EN
    ,
    .words_delivered (words_delivered),
    .grants_issued   (grants_issued)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int total_pops    = 0;
  int total_accepts = 0;
  logic [DW-1:0] mem[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] next_word = 8'h11;
  bit auto_fill  = 1'b0;
  bit hold_empty = 1'b0;

  task automatic push_words(input int n);
    repeat (n) begin
      mem.push_back(next_word);
      next_word = next_word + 8'h13;
    end
  endtask

  task automatic settle();
    if (auto_fill) while (mem.size() < 8) push_words(1);
    bus.fifo_empty = hold_empty || (mem.size() == 0);
    if (bus.fifo_empty) bus.fifo_read_data = '0;
    else bus.fifo_read_data = mem[0];
    #1;
  endtask

  task automatic advance();
    logic [DW-1:0] exp;
    n_checks++;
    if (!$onehot0(bus.out_valid)) begin
      n_fail++;
      $display("FAIL out_valid_onehot: got %b required one-hot-or-zero", bus.out_valid);
    end
    if (|(bus.out_valid & bus.out_ready)) begin
      n_checks++;
      total_accepts++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: got word %h required none pending", bus.out_data);
      end else begin
        exp = exp_q.pop_front();
        if (bus.out_data !== exp) begin
          n_fail++;
          $display("FAIL delivered_word: got %h required %h", bus.out_data, exp);
        end
      end
    end
    n_checks++;
    if (bus.fifo_increment && bus.fifo_empty) begin
      n_fail++;
      $display("FAIL pop_when_empty: got fifo_increment=1 required 0");
    end
    if (bus.fifo_increment && !bus.fifo_empty) begin
      exp_q.push_back(mem.pop_front());
      total_pops++;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic do_reset();
    bus.req = '0;
    bus.out_ready = '0;
    bus.fifo_empty = 1'b1;
    bus.fifo_read_data = '0;
    hold_empty = 1'b0;
    auto_fill = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    mem.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle();
    int i;
    bus.req = '0;
    bus.out_ready = '1;
    i = 0;
    while (i < 30 && (bus.busy || bus.out_valid != '0)) begin
      cycle();
      i++;
    end
    n_checks++;
    if (bus.busy || bus.out_valid != '0) begin
      n_fail++;
      $display("FAIL idle_timeout: got busy=%b out_valid=%b required 0", bus.busy, bus.out_valid);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL words_undelivered: got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    bus.req = '1;
    bus.out_ready = '1;
    bus.fifo_empty = 1'b0;
    bus.fifo_read_data = 8'hA5;
    @(negedge clock);
    #1;
    n_checks++;
    if (bus.out_valid !== '0 || bus.grant !== '0 || bus.busy !== 1'b0 ||
        bus.fifo_increment !== 1'b0 || bus.out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b grant=%b busy=%b inc=%b data=%h required all 0",
               bus.out_valid, bus.grant, bus.busy, bus.fifo_increment, bus.out_data);
    end
`ifdef CDC_FIFO_ARB_STATS_EN
    n_checks++;
    if (words_delivered !== 16'd0 || grants_issued !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_stats: got %0d/%0d required 0/0", words_delivered, grants_issued);
    end
`endif
  endtask

  task automatic test_single();
    bit exp_inc [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int acc0;
    do_reset();
    acc0 = total_accepts;
    push_words(6);
    bus.req = 4'b0001;
    bus.out_ready = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      settle();
      n_checks++;
      if (bus.fifo_increment !== exp_inc[c]) begin
        n_fail++;
        $display("FAIL single_inc_c%0d: got %b required %b", c, bus.fifo_increment, exp_inc[c]);
      end
      if (c == 2) begin
        n_checks++;
        if (bus.out_valid !== 4'b0001) begin
          n_fail++;
          $display("FAIL single_valid: got %b required 0001", bus.out_valid);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (bus.grant !== 4'b0001 || bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL single_drain: got grant=%b busy=%b required 0001/1", bus.grant, bus.busy);
        end
      end
      if (c == 6) begin
        n_checks++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL single_gap: got grant=%b busy=%b required 0000/0", bus.grant, bus.busy);
        end
      end
      advance();
    end
    wait_idle();
    n_checks++;
    if (total_accepts - acc0 != 6) begin
      n_fail++;
      $display("FAIL single_count: got %0d words required 6", total_accepts - acc0);
    end
`ifdef CDC_FIFO_ARB_STATS_EN
    n_checks++;
    if (words_delivered !== 16'd6 || grants_issued !== 16'd2) begin
      n_fail++;
      $display("FAIL single_stats: got %0d/%0d required 6/2", words_delivered, grants_issued);
    end
`endif
  endtask

  task automatic test_fairness();
    logic [N-1:0] seen [5];
    int words [5];
    logic [N-1:0] prev;
    logic [N-1:0] exp_g;
    int k;
    int c;
    do_reset();
    auto_fill = 1'b1;
    bus.req = 4'b1111;
    bus.out_ready = 4'b1111;
    prev = '0;
    k = -1;
    c = 0;
    for (int i = 0; i < 5; i++) begin
      seen[i] = '0;
      words[i] = 0;
    end
    while (k < 4 && c < 80) begin
      settle();
      if (bus.grant != '0 && prev == '0) begin
        k++;
        seen[k] = bus.grant;
      end
      if (bus.fifo_increment && k >= 0) words[k]++;
      prev = bus.grant;
      advance();
      c++;
    end
    n_checks++;
    if (k < 4) begin
      n_fail++;
      $display("FAIL fairness_timeout: got %0d grants required 5", k + 1);
    end
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      n_checks++;
      if (seen[i] !== exp_g) begin
        n_fail++;
        $display("FAIL fairness_grant_%0d: got %b required %b", i, seen[i], exp_g);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (words[i] != MB) begin
        n_fail++;
        $display("FAIL fairness_words_%0d: got %0d required %0d", i, words[i], MB);
      end
    end
    auto_fill = 1'b0;
    wait_idle();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w0;
    int pops0;
    do_reset();
    push_words(6);
    w0 = mem[0];
    pops0 = total_pops;
    bus.req = 4'b0100;
    bus.out_ready = 4'b1011;
    cycle();
    settle();
    n_checks++;
    if (bus.fifo_increment !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first_load: got %b required 1", bus.fifo_increment);
    end
    advance();
    for (int c = 0; c < 5; c++) begin
      settle();
      n_checks++;
      if (bus.fifo_increment !== 1'b0 || bus.out_valid !== 4'b0100 || bus.out_data !== w0) begin
        n_fail++;
        $display("FAIL bp_hold_c%0d: got inc=%b valid=%b data=%h required 0/0100/%h",
                 c, bus.fifo_increment, bus.out_valid, bus.out_data, w0);
      end
      advance();
    end
    n_checks++;
    if (total_pops - pops0 != 1) begin
      n_fail++;
      $display("FAIL bp_pop_count: got %0d required 1", total_pops - pops0);
    end
    bus.out_ready = 4'b1111;
    settle();
    n_checks++;
    if (bus.fifo_increment !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_resume: got %b required 1", bus.fifo_increment);
    end
    advance();
    wait_idle();
  endtask

  task automatic test_empty_stall();
    do_reset();
    push_words(2);
    bus.req = 4'b0001;
    bus.out_ready = 4'b1111;
    repeat (3) cycle();
    for (int c = 0; c < 3; c++) begin
      settle();
      n_checks++;
      if (bus.fifo_increment !== 1'b0 || bus.grant !== 4'b0001) begin
        n_fail++;
        $display("FAIL stall_c%0d: got inc=%b grant=%b required 0/0001",
                 c, bus.fifo_increment, bus.grant);
      end
      advance();
    end
    push_words(2);
    settle();
    n_checks++;
    if (bus.fifo_increment !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_resume: got %b required 1", bus.fifo_increment);
    end
    advance();
    wait_idle();
  endtask

  task automatic test_req_drop();
    logic [DW-1:0] w0;
    do_reset();
    push_words(3);
    w0 = mem[0];
    bus.req = 4'b0010;
    bus.out_ready = 4'b0000;
    cycle();
    cycle();
    bus.req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_checks++;
      if (bus.fifo_increment !== 1'b0 || bus.out_valid !== 4'b0010 || bus.out_data !== w0) begin
        n_fail++;
        $display("FAIL drop_hold_c%0d: got inc=%b valid=%b data=%h required 0/0010/%h",
                 c, bus.fifo_increment, bus.out_valid, bus.out_data, w0);
      end
      advance();
    end
    bus.out_ready = 4'b0010;
    cycle();
    bus.req = 4'b1111;
    bus.out_ready = 4'b1111;
    settle();
    n_checks++;
    if (bus.grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL drop_idle: got grant=%b required 0000", bus.grant);
    end
    advance();
    settle();
    n_checks++;
    if (bus.grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL drop_next_grant: got %b required 0100", bus.grant);
    end
    advance();
    wait_idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    push_words(4);
    bus.req = 4'b0001;
    bus.out_ready = 4'b0000;
    cycle();
    cycle();
    settle();
    n_checks++;
    if (bus.out_valid !== 4'b0001) begin
      n_fail++;
      $display("FAIL areset_pre: got valid=%b required 0001", bus.out_valid);
    end
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== '0 || bus.grant !== '0 || bus.busy !== 1'b0 || bus.fifo_increment !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_now: got valid=%b grant=%b busy=%b inc=%b required 0",
               bus.out_valid, bus.grant, bus.busy, bus.fifo_increment);
    end
`ifdef CDC_FIFO_ARB_STATS_EN
    n_checks++;
    if (words_delivered !== 16'd0 || grants_issued !== 16'd0) begin
      n_fail++;
      $display("FAIL areset_stats: got %0d/%0d required 0/0", words_delivered, grants_issued);
    end
`endif
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    mem.delete();
    bus.req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_empty_stall();
    test_req_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
